// File: rtl/swap_ctrl.sv
// Sequences atomic SWAP/COPY on a single-write, async-read register file and arbitrates it with a host port.
// Latency: SWAP done at T+4, COPY at T+2, a==b or reserved op at T+1; while busy, host ready/valid drop and start is ignored.
module swap_ctrl #(
    parameter int N     = 7,
    parameter int BITS  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [N-1:0]     addr_a,
    input  logic [N-1:0]     addr_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cmd_cnt,
    input  logic             host_w_en,
    input  logic [N-1:0]     host_w_address,
    input  logic [BITS-1:0]  host_w_data,
    output logic             host_w_ready,
    input  logic [N-1:0]     host_r_address,
    output logic [BITS-1:0]  host_r_data,
    output logic             host_r_valid,
    output logic             mem_w_en,
    output logic [N-1:0]     mem_w_address,
    output logic [BITS-1:0]  mem_w_data,
    output logic [N-1:0]     mem_r_address,
    input  logic [BITS-1:0]  mem_r_data
);

    typedef enum logic [2:0] {IDLE, RD_A, WR_A, WR_B, CPY, FIN} state_t;

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic [N-1:0]    a_q, b_q;
    logic [BITS-1:0] temp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op[1] || addr_a == addr_b) state_nxt = FIN;
                    else if (op[0])                state_nxt = CPY;
                    else                           state_nxt = RD_A;
                end
            end
            RD_A:    state_nxt = WR_A;
            WR_A:    state_nxt = WR_B;
            WR_B:    state_nxt = FIN;
            CPY:     state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands latch only on acceptance; temp holds mem[a] across the two swap writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            temp    <= '0;
            cmd_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                op_q <= op;
                a_q  <= addr_a;
                b_q  <= addr_b;
            end
            if (state == RD_A)
                temp <= mem_r_data;
            if (state == FIN && !op_q[1] && cmd_cnt != {CNT_W{1'b1}})
                cmd_cnt <= cmd_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mem_r_address = host_r_address;
        mem_w_en      = 1'b0;
        mem_w_address = host_w_address;
        mem_w_data    = host_w_data;
        case (state)
            IDLE: mem_w_en = host_w_en;
            RD_A: mem_r_address = a_q;
            WR_A: begin
                mem_r_address = b_q;
                mem_w_en      = 1'b1;
                mem_w_address = a_q;
                mem_w_data    = mem_r_data;
            end
            WR_B: begin
                mem_w_en      = 1'b1;
                mem_w_address = b_q;
                mem_w_data    = temp;
            end
            CPY: begin
                mem_r_address = a_q;
                mem_w_en      = 1'b1;
                mem_w_address = b_q;
                mem_w_data    = mem_r_data;
            end
            default: ;
        endcase
    end

    assign busy         = (state != IDLE);
    assign done         = (state == FIN);
    assign err          = (state == FIN) && op_q[1];
    assign host_w_ready = !busy;
    assign host_r_valid = !busy;
    assign host_r_data  = mem_r_data;

endmodule

// File: tb/tb_swap_ctrl.sv
// Bench for swap_ctrl: behavioural register-file contents and command counter, random and directed commands.
module tb_swap_ctrl;
    localparam int N = 7, BITS = 8, CNT_W = 16, DEPTH = 128;

    logic clk = 1'b0, rstn;
    logic start;
    logic [1:0] op;
    logic [N-1:0] addr_a, addr_b;
    logic busy, done, err;
    logic [CNT_W-1:0] cmd_cnt;
    logic host_w_en;
    logic [N-1:0] host_w_address, host_r_address;
    logic [BITS-1:0] host_w_data, host_r_data;
    logic host_w_ready, host_r_valid;
    logic mem_w_en;
    logic [N-1:0] mem_w_address, mem_r_address;
    logic [BITS-1:0] mem_w_data, mem_r_data;

    swap_ctrl #(.N(N), .BITS(BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .addr_a(addr_a), .addr_b(addr_b),
        .busy(busy), .done(done), .err(err), .cmd_cnt(cmd_cnt),
        .host_w_en(host_w_en), .host_w_address(host_w_address), .host_w_data(host_w_data),
        .host_w_ready(host_w_ready), .host_r_address(host_r_address), .host_r_data(host_r_data),
        .host_r_valid(host_r_valid), .mem_w_en(mem_w_en), .mem_w_address(mem_w_address),
        .mem_w_data(mem_w_data), .mem_r_address(mem_r_address), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    // Register file the controller fronts, plus event counters.
    logic [BITS-1:0] rf [DEPTH];
    int wr_count = 0, done_count = 0;
    always @(posedge clk) begin
        if (mem_w_en) begin
            rf[mem_w_address] <= mem_w_data;
            wr_count <= wr_count + 1;
        end
        if (done) done_count <= done_count + 1;
    end
    assign mem_r_data = rf[mem_r_address];

    logic [BITS-1:0] exp_mem [DEPTH];
    int exp_cnt = 0;
    int n_cmp = 0, n_err = 0;

    function automatic int cmd_latency(input logic [1:0] o, input int a, input int b);
        if (o[1] || a == b) return 1;
        return (o == 2'b00) ? 4 : 2;
    endfunction

    function automatic int cmd_writes(input logic [1:0] o, input int a, input int b);
        if (o[1] || a == b) return 0;
        return (o == 2'b00) ? 2 : 1;
    endfunction

    task automatic model_cmd(input logic [1:0] o, input int a, input int b);
        logic [BITS-1:0] t;
        if (o[1]) return;
        if (a != b) begin
            if (o == 2'b00) begin
                t = exp_mem[a]; exp_mem[a] = exp_mem[b]; exp_mem[b] = t;
            end else begin
                exp_mem[b] = exp_mem[a];
            end
        end
        if (exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic host_write(input int a, input logic [BITS-1:0] d);
        host_w_en = 1'b1; host_w_address = N'(a); host_w_data = d;
        n_cmp++;
        if (host_w_ready !== 1'b1) begin n_err++; $display("FAIL host_ready idle: got %b want 1", host_w_ready); end
        exp_mem[a] = d;
        @(negedge clk);
        host_w_en = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            host_r_address = N'(i);
            @(negedge clk);
            n_cmp++;
            if (host_r_data !== exp_mem[i] || host_r_valid !== 1'b1) begin
                n_err++;
                $display("FAIL %s mem[%0d]: got %h valid %b want %h valid 1", tag, i, host_r_data, host_r_valid, exp_mem[i]);
            end
        end
    endtask

    // Issue one command (optionally with a simultaneous host write) and check its whole lifetime.
    task automatic run_cmd(input logic [1:0] o, input int a, input int b, input bit hw,
                           input int hwa, input logic [BITS-1:0] hwd, input string tag);
        int k, w0, lat, nw;
        lat = cmd_latency(o, a, b);
        nw  = cmd_writes(o, a, b) + (hw ? 1 : 0);
        w0  = wr_count;
        start = 1'b1; op = o; addr_a = N'(a); addr_b = N'(b);
        host_w_en = hw; host_w_address = N'(hwa); host_w_data = hwd;
        if (hw) exp_mem[hwa] = hwd;
        @(negedge clk);
        start = 1'b0; host_w_en = 1'b0;
        k = 1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy after accept: got %b want 1", tag, busy); end
        while (done !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL %s done timeout: got none within %0d cycles want T+%0d", tag, k, lat);
        end else if (k != lat || err !== o[1]) begin
            n_err++; $display("FAIL %s done: got T+%0d err %b want T+%0d err %b", tag, k, err, lat, o[1]);
        end
        model_cmd(o, a, b);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cmd_cnt !== CNT_W'(exp_cnt) || wr_count - w0 != nw) begin
            n_err++;
            $display("FAIL %s post: got busy %b cnt %0d writes %0d want busy 0 cnt %0d writes %0d",
                     tag, busy, cmd_cnt, wr_count - w0, exp_cnt, nw);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0; op = 2'b00; addr_a = '0; addr_b = '0;
        host_w_en = 1'b0; host_w_address = '0; host_w_data = '0; host_r_address = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_cnt !== '0 || host_w_ready !== 1'b1 || mem_w_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got busy %b done %b err %b cnt %0d ready %b wen %b want 0 0 0 0 1 0",
                     busy, done, err, cmd_cnt, host_w_ready, mem_w_en);
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) host_write(i, BITS'($urandom));
    endtask

    task automatic test_swap();
        host_write(3, 8'h11);
        host_write(9, 8'h22);
        run_cmd(2'b00, 3, 9, 1'b0, 0, 8'h00, "swap");
        check_mem("swap");
    endtask

    task automatic test_copy_same();
        host_write(5, 8'hA5);
        run_cmd(2'b01, 5, 6, 1'b0, 0, 8'h00, "copy");
        run_cmd(2'b00, 7, 7, 1'b0, 0, 8'h00, "same_addr");
        check_mem("copy_same");
    endtask

    task automatic test_busy_arb();
        int k, d0;
        logic [BITS-1:0] m20;
        m20 = exp_mem[20];
        d0 = done_count;
        start = 1'b1; op = 2'b00; addr_a = N'(3); addr_b = N'(9);
        @(negedge clk);
        k = 1;
        start = 1'b1; op = 2'b01; addr_a = N'(1); addr_b = N'(2);
        host_w_en = 1'b1; host_w_address = N'(20); host_w_data = 8'h77;
        n_cmp++;
        if (host_w_ready !== 1'b0 || host_r_valid !== 1'b0) begin
            n_err++; $display("FAIL arb ready/valid: got %b/%b want 0/0", host_w_ready, host_r_valid);
        end
        while (done !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_cmp++;
        if (k != 4) begin n_err++; $display("FAIL arb done latency: got T+%0d want T+4", k); end
        start = 1'b0; host_w_en = 1'b0;
        model_cmd(2'b00, 3, 9);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (done_count - d0 != 1 || cmd_cnt !== CNT_W'(exp_cnt)) begin
            n_err++; $display("FAIL arb dones: got %0d cnt %0d want 1 cnt %0d", done_count - d0, cmd_cnt, exp_cnt);
        end
        host_r_address = N'(20);
        #1;
        n_cmp++;
        if (host_r_data !== m20) begin n_err++; $display("FAIL arb mem20: got %h want %h", host_r_data, m20); end
        @(negedge clk);
    endtask

    task automatic test_same_cycle();
        host_write(9, 8'h22);
        run_cmd(2'b00, 3, 9, 1'b1, 3, 8'h55, "same_cycle");
        check_mem("same_cycle");
    endtask

    task automatic test_reserved();
        run_cmd(2'b10, 11, 12, 1'b0, 0, 8'h00, "reserved10");
        run_cmd(2'b11, 13, 13, 1'b0, 0, 8'h00, "reserved11");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [1:0] o;
            int a, b;
            bit hw;
            o  = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            a  = $urandom_range(0, DEPTH - 1);
            b  = ($urandom_range(0, 5) == 0) ? a : $urandom_range(0, DEPTH - 1);
            hw = ($urandom_range(0, 3) == 0);
            run_cmd(o, a, b, hw, $urandom_range(0, DEPTH - 1), BITS'($urandom), "random");
        end
        check_mem("random");
    endtask

    task automatic test_reset_mid();
        int w0;
        start = 1'b1; op = 2'b00; addr_a = N'(40); addr_b = N'(41);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_cnt !== '0) begin
            n_err++; $display("FAIL reset_mid: got busy %b done %b cnt %0d want 0 0 0", busy, done, cmd_cnt);
        end
        exp_mem[40] = exp_mem[41];
        exp_cnt = 0;
        w0 = wr_count;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (wr_count != w0 || done_count < 0) begin
            n_err++; $display("FAIL reset_mid writes: got %0d extra want 0", wr_count - w0);
        end
        check_mem("reset_mid");
    endtask

    initial begin
        test_reset();
        test_swap();
        test_copy_same();
        test_busy_arb();
        test_same_cycle();
        test_reserved();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
